// File: rtl/rv32i_mc_control_unit.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXE/MEM/WB sequencer with bus wait-state handshake and TRAP lock.
// Optional performance counters are enabled by defining RV32I_MC_PERF_EN.
module rv32i_mc_control_unit #(
  parameter int BUS_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        PCEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        busReq,
  output logic        busWe,
  output logic        busError
`ifdef RV32I_MC_PERF_EN
  ,
  output logic [31:0] perfCycle,
  output logic [31:0] perfInstret
`endif
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXE, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t            r_state;
  logic [31:0]       r_ir;
  logic [TO_W-1:0]   r_to_cnt;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_f7b5;
  logic       w_is_r, w_is_i, w_is_ld, w_is_st, w_is_b;
  logic       w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal;
  logic       w_unused_ir;

  assign w_opcode    = r_ir[6:0];
  assign w_funct3    = r_ir[14:12];
  assign w_f7b5      = r_ir[30];
  assign w_unused_ir = ^{r_ir[31], r_ir[29:15], r_ir[11:7]};

  assign w_is_r     = (w_opcode == OP_R);
  assign w_is_i     = (w_opcode == OP_I);
  assign w_is_ld    = (w_opcode == OP_LD);
  assign w_is_st    = (w_opcode == OP_ST);
  assign w_is_b     = (w_opcode == OP_B);
  assign w_is_jal   = (w_opcode == OP_JAL);
  assign w_is_jalr  = (w_opcode == OP_JALR);
  assign w_is_lui   = (w_opcode == OP_LUI);
  assign w_is_auipc = (w_opcode == OP_AUIPC);
  assign w_legal    = w_is_r | w_is_i | w_is_ld | w_is_st | w_is_b |
                      w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_ir     <= 32'h0000_0013;
      r_to_cnt <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir    <= instrCode;
          r_state <= S_DECODE;
        end
        S_DECODE: r_state <= w_legal ? S_EXE : S_TRAP;
        S_EXE: begin
          if (w_is_ld || w_is_st) begin
            r_state  <= S_MEM;
            r_to_cnt <= '0;
          end else begin
            r_state <= S_FETCH;
          end
        end
        // A ready slave on the final allowed cycle still completes the access.
        S_MEM: begin
          if (busReady) begin
            r_state <= w_is_ld ? S_WB : S_FETCH;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt == TO_LAST) r_state <= S_TRAP;
          end
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCEn      = 1'b0;
    regFileWe = 1'b0;
    busReq    = 1'b0;
    busWe     = 1'b0;
    case (r_state)
      S_EXE: begin
        if (!(w_is_ld || w_is_st)) begin
          PCEn      = 1'b1;
          regFileWe = !w_is_b;
        end
      end
      S_MEM: begin
        busReq = 1'b1;
        busWe  = w_is_st;
        PCEn   = w_is_st & busReady;
      end
      S_WB: begin
        PCEn      = 1'b1;
        regFileWe = 1'b1;
      end
      default: ;
    endcase
  end

  assign busError = (r_state == S_TRAP);

  always_comb begin
    aluControl = 4'b0000;
    if (w_is_r)      aluControl = {w_f7b5, w_funct3};
    else if (w_is_i) aluControl = (w_funct3 == 3'b101) ? {w_f7b5, 3'b101} : {1'b0, w_funct3};
    else if (w_is_b) aluControl = {1'b0, w_funct3};
  end

  always_comb begin
    RFWDSrcMuxSel = 3'd0;
    if (w_is_ld)                     RFWDSrcMuxSel = 3'd1;
    else if (w_is_lui)               RFWDSrcMuxSel = 3'd2;
    else if (w_is_auipc)             RFWDSrcMuxSel = 3'd3;
    else if (w_is_jal || w_is_jalr)  RFWDSrcMuxSel = 3'd4;
  end

  assign aluSrcMuxSel = w_is_i | w_is_ld | w_is_st | w_is_jalr;
  assign branch       = w_is_b;
  assign jal          = w_is_jal;
  assign jalr         = w_is_jalr;

`ifdef RV32I_MC_PERF_EN
  logic [31:0] r_perf_cycle;
  logic [31:0] r_perf_instret;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cycle   <= '0;
      r_perf_instret <= '0;
    end else begin
      if (r_state != S_TRAP) r_perf_cycle <= r_perf_cycle + 32'd1;
      if (PCEn)              r_perf_instret <= r_perf_instret + 32'd1;
    end
  end

  assign perfCycle   = r_perf_cycle;
  assign perfInstret = r_perf_instret;
`endif

endmodule

// File: tb/tb_rv32i_mc_control_unit.sv
// Bench for rv32i_mc_control_unit: per-instruction timelines built from the instruction-class rules.
`timescale 1ns/1ps
module tb_rv32i_mc_control_unit;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrCode;
  logic        busReady;
  logic        PCEn, regFileWe, aluSrcMuxSel, branch, jal, jalr, busReq, busWe, busError;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;
`ifdef RV32I_MC_PERF_EN
  logic [31:0] perfCycle, perfInstret;
  int unsigned m_cyc, m_ret;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rv32i_mc_control_unit #(.BUS_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .instrCode(instrCode), .busReady(busReady),
    .PCEn(PCEn), .regFileWe(regFileWe), .aluControl(aluControl),
    .aluSrcMuxSel(aluSrcMuxSel), .RFWDSrcMuxSel(RFWDSrcMuxSel),
    .branch(branch), .jal(jal), .jalr(jalr),
    .busReq(busReq), .busWe(busWe), .busError(busError)
`ifdef RV32I_MC_PERF_EN
    , .perfCycle(perfCycle), .perfInstret(perfInstret)
`endif
  );

  logic [4:0]  obs_vec;
  logic [10:0] obs_dec;
  assign obs_vec = {PCEn, regFileWe, busReq, busWe, busError};
  assign obs_dec = {aluControl, aluSrcMuxSel, RFWDSrcMuxSel, branch, jal, jalr};

  typedef struct packed {
    logic [3:0] alu;
    logic       src;
    logic [2:0] rfwd;
    logic       br, jl, jr, legal, ld, st;
  } dec_t;

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  function automatic dec_t ref_dec(input logic [31:0] ins);
    dec_t d;
    logic [2:0] f3;
    d  = '0;
    f3 = ins[14:12];
    case (ins[6:0])
      7'b0110011: begin d.legal = 1; d.alu = {ins[30], f3}; end
      7'b0010011: begin d.legal = 1; d.src = 1; d.alu = (f3 == 3'b101) ? {ins[30], f3} : {1'b0, f3}; end
      7'b0000011: begin d.legal = 1; d.src = 1; d.rfwd = 3'd1; d.ld = 1; end
      7'b0100011: begin d.legal = 1; d.src = 1; d.st = 1; end
      7'b1100011: begin d.legal = 1; d.br = 1; d.alu = {1'b0, f3}; end
      7'b1101111: begin d.legal = 1; d.jl = 1; d.rfwd = 3'd4; end
      7'b1100111: begin d.legal = 1; d.jr = 1; d.src = 1; d.rfwd = 3'd4; end
      7'b0110111: begin d.legal = 1; d.rfwd = 3'd2; end
      7'b0010111: begin d.legal = 1; d.rfwd = 3'd3; end
      default: ;
    endcase
    return d;
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    busReady  = 1'b0;
    instrCode = $urandom;
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef RV32I_MC_PERF_EN
    m_cyc = 0;
    m_ret = 0;
`endif
  endtask

  // Entered at the start of a FETCH cycle; expected timeline: {PCEn,regFileWe,busReq,busWe,busError}.
  task automatic exec_instr(input logic [31:0] ins, input int waits, input string tag, output bit trapped);
    dec_t        d;
    logic [10:0] exp_dec;
    logic [4:0]  eq[$];
    bit          rq[$];
    d       = ref_dec(ins);
    exp_dec = {d.alu, d.src, d.rfwd, d.br, d.jl, d.jr};
    trapped = 0;
    eq.push_back(5'b00000); rq.push_back(1'($urandom_range(0, 1)));
    eq.push_back(5'b00000); rq.push_back(1'($urandom_range(0, 1)));
    if (!d.legal) begin
      repeat (3) begin eq.push_back(5'b00001); rq.push_back(1'($urandom_range(0, 1))); end
      trapped = 1;
    end else if (!(d.ld || d.st)) begin
      eq.push_back({1'b1, !d.br, 3'b000}); rq.push_back(1'($urandom_range(0, 1)));
    end else begin
      eq.push_back(5'b00000); rq.push_back(1'($urandom_range(0, 1)));
      for (int m = 1; m <= TO; m++) begin
        if (m > waits) begin
          eq.push_back({d.st, 1'b0, 1'b1, d.st, 1'b0}); rq.push_back(1'b1);
          if (d.ld) begin eq.push_back(5'b11000); rq.push_back(1'($urandom_range(0, 1))); end
          break;
        end
        eq.push_back({2'b00, 1'b1, d.st, 1'b0}); rq.push_back(1'b0);
        if (m == TO) begin
          repeat (3) begin eq.push_back(5'b00001); rq.push_back(1'($urandom_range(0, 1))); end
          trapped = 1;
        end
      end
    end
    for (int c = 0; c < eq.size(); c++) begin
      instrCode = (c == 0) ? ins : $urandom;
      busReady  = rq[c];
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== eq[c]) begin
        n_bad++;
        $display("FAIL %s ins=%h cyc%0d enables{PCEn,We,Req,BWe,Err} got=%b want=%b", tag, ins, c + 1, obs_vec, eq[c]);
      end
      if (c >= 1) begin
        n_cmp++;
        if (obs_dec !== exp_dec) begin
          n_bad++;
          $display("FAIL %s ins=%h cyc%0d decode{alu,src,rfwd,br,jal,jalr} got=%b want=%b", tag, ins, c + 1, obs_dec, exp_dec);
        end
      end
`ifdef RV32I_MC_PERF_EN
      n_cmp++;
      if (perfCycle !== m_cyc || perfInstret !== m_ret) begin
        n_bad++;
        $display("FAIL %s perf cyc%0d got=%0d/%0d want=%0d/%0d", tag, c + 1, perfCycle, perfInstret, m_cyc, m_ret);
      end
      if (!eq[c][0]) m_cyc++;
      if (eq[c][4])  m_ret++;
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; busReady = 1'b1; instrCode = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      instrCode = $urandom; busReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== 5'b00000) begin
        n_bad++; $display("FAIL reset_enables got=%b want=00000", obs_vec);
      end
      n_cmp++;
      if (obs_dec !== {4'b0000, 1'b1, 3'd0, 3'b000}) begin
        n_bad++; $display("FAIL reset_ir_nop decode got=%b want=%b", obs_dec, {4'b0000, 1'b1, 3'd0, 3'b000});
      end
`ifdef RV32I_MC_PERF_EN
      n_cmp++;
      if (perfCycle !== 0 || perfInstret !== 0) begin
        n_bad++; $display("FAIL reset_perf got=%0d/%0d want=0/0", perfCycle, perfInstret);
      end
`endif
      @(posedge clk); #1;
    end
    do_reset();
  endtask

  task automatic test_directed();
    bit t;
    exec_instr(32'h002081B3, 0, "add", t);
    exec_instr(32'h402081B3, 0, "sub", t);
    exec_instr(32'h4020D093, 0, "srai", t);
    exec_instr(32'h0000A283, 3, "lw_wait3", t);
    exec_instr(32'h0050A223, 0, "sw_nowait", t);
    exec_instr(32'h00208463, 0, "beq", t);
    exec_instr(32'h008000EF, 0, "jal", t);
    exec_instr(32'h000080E7, 0, "jalr", t);
    exec_instr(32'h123450B7, 0, "lui", t);
    exec_instr(32'h00001097, 0, "auipc", t);
    exec_instr(32'h0050A223, 14, "sw_wait14", t);
    exec_instr(32'h0000A283, 14, "lw_ready_on_last", t);
  endtask

  task automatic test_timeout();
    bit t;
    do_reset();
    exec_instr(32'h0000A283, 1000, "lw_timeout", t);
    do_reset();
    exec_instr(32'h002081B3, 0, "after_timeout_reset", t);
    exec_instr(32'h0050A223, 1000, "sw_timeout", t);
    do_reset();
  endtask

  task automatic test_illegal();
    bit t;
    do_reset();
    exec_instr(32'h002081B3, 0, "pre_illegal", t);
    exec_instr(32'hFFFF_FFFF, 0, "illegal_ffff", t);
    do_reset();
    exec_instr(32'h0000_0000, 0, "illegal_zero", t);
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    bit t;
    logic [4:0] want [5] = '{5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00100};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      instrCode = (c == 0) ? 32'h0000A283 : $urandom;
      busReady  = 1'b0;
      if (c == 4) reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (obs_vec !== want[c]) begin
        n_bad++; $display("FAIL mid_mem cyc%0d got=%b want=%b", c + 1, obs_vec, want[c]);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
`ifdef RV32I_MC_PERF_EN
    m_cyc = 0;
    m_ret = 0;
`endif
    exec_instr(32'h002081B3, 0, "after_mid_mem_reset", t);
  endtask

  task automatic test_back_to_back();
    bit          t;
    logic [31:0] ins;
    dec_t        d;
    int          sel;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 19);
      ins = $urandom;
      if (sel == 0) begin
        d = ref_dec(ins);
        while (d.legal) begin ins = $urandom; d = ref_dec(ins); end
        exec_instr(ins, 0, "rnd_illegal", t);
      end else if (sel == 1) begin
        ins[6:0] = legal_ops[2 + $urandom_range(0, 1)];
        exec_instr(ins, TO + 5, "rnd_timeout", t);
      end else begin
        ins[6:0] = legal_ops[$urandom_range(0, 8)];
        exec_instr(ins, $urandom_range(0, 4), "rnd", t);
      end
      if (t) do_reset();
    end
  endtask

  initial begin
    reset = 1'b1; busReady = 1'b0; instrCode = 32'h0;
    test_reset();
    test_directed();
    test_timeout();
    test_illegal();
    test_reset_mid_mem();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
